mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Decodes opcode/funct from the
//  instruction register and sequences PC, memory, register file and the shared 32-bit
//  ALU one state per cycle, including the 4-bit ALU operation code.
//  Sits between the instruction register and all datapath muxes/enables.
// PARAMETERS
//  COUNT_WIDTH  32  width of retired-instruction counter instr_count (wraps modulo 2^N)
// PORTS
//  clock          in   1   rising-edge clock
//  reset_n        in   1   asynchronous, active-low reset
//  opcode         in   6   instr[31:26], stable from DECODE until next FETCH
//  funct          in   6   instr[5:0]
//  zero           in   1   ALU zero flag (operands equal)
//  mem_ready      in   1   memory completes the access this cycle
//  pc_en          out  1   PC load (unconditional, or beq with zero resolved inside)
//  ir_write       out  1   instruction register load
//  mem_read       out  1   memory read strobe
//  mem_write      out  1   memory write strobe
//  i_or_d         out  1   memory address: 0=PC, 1=ALUOut
//  reg_write      out  1   register file write
//  reg_dst        out  1   dest reg: 0=rt, 1=rd
//  mem_to_reg     out  1   writeback data: 0=ALUOut, 1=MDR
//  alu_src_a      out  1   0=PC, 1=regA
//  alu_src_b      out  2   00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  pc_source      out  2   00=ALU result, 01=ALUOut, 10=jump target
//  alu_operation  out  4   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//  illegal_op     out  1   unsupported opcode/funct seen in DECODE (1-cycle)
//  instr_count    out  COUNT_WIDTH  instructions fetched since reset
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; instr_count=0; asserting reset_n=0 in any state aborts at once.
//  Outputs Moore decode of state; exceptions pc_en (BRANCH, FETCH) and illegal_op (DECODE) also use inputs.
//  Any output not listed for a state is 0.
//  IDLE: all 0 -> FETCH next cycle.
//  FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_operation=ADD, pc_source=00;
//   mem_ready=0: hold in FETCH, pc_en=ir_write=0. mem_ready=1: pc_en=ir_write=1,
//   instr_count+1 at the clock edge, -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target). Next on opcode:
//   0x23 lw / 0x2B sw -> MEM_ADDR; 0x00 R-type -> EXECUTE; 0x04 beq -> BRANCH;
//   0x02 j -> JUMP; 0x08 addi -> ADDI_EXEC. Other opcode, or R-type with funct not in
//   {0x20,0x22,0x24,0x25,0x27,0x2A}: illegal_op=1 this cycle only, -> FETCH, no writeback.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD -> MEM_READ (lw) or MEM_WRITE (sw).
//  MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1 -> MEM_WB.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1 -> FETCH.
//  EXECUTE: alu_src_a=1, alu_src_b=00, alu_operation from funct:
//   0x24 AND, 0x25 OR, 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x27 NOR -> R_WB.
//  R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_en=zero -> FETCH.
//  JUMP: pc_source=10, pc_en=1 -> FETCH.
//  ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD -> ADDI_WB.
//  ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//  Any unreachable state encoding -> IDLE.
//  Latency with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
//  mem_write and reg_write are never 1 in the same cycle.
//  Counter wrap: all-ones +1 -> 0, no flag.
// STRUCTURE
//  Package mips_defs_pkg: opcode and funct constants, ALU operation codes,
//   alu_src_b/pc_source encodings, state encoding localparams (4-bit).
//  Sub-module alu_funct_decoder (combinational): funct -> alu_operation[3:0] plus
//   funct_legal; shared with DECODE illegal check and EXECUTE.
// TESTING
//  1. Release reset, opcode=0x23, mem_ready=1 -> IDLE,FETCH,DECODE,MEM_ADDR,MEM_READ,MEM_WB;
//     MEM_WB has reg_write=1, mem_to_reg=1; instr_count=1.
//  2. R-type funct=0x22 -> EXECUTE alu_operation=0110; R_WB reg_write=1, reg_dst=1.
//     Repeat funct=0x2A -> alu_operation=0111.
//  3. beq: zero=1 in BRANCH -> pc_en=1, pc_source=01; zero=0 -> pc_en=0; both then FETCH.
//  4. FETCH with mem_ready=0 for 3 cycles -> mem_read=1, pc_en=ir_write=0,
//     instr_count unchanged; mem_ready=1 on 4th cycle -> DECODE next.
//  5. opcode=0x3F, then R-type funct=0x00 -> illegal_op=1 for one DECODE cycle each,
//     then FETCH; reg_write/mem_write never asserted.
//  6. reset_n=0 mid MEM_WRITE with mem_ready=0 -> all outputs 0 immediately,
//     instr_count=0; after release, sequence restarts at IDLE.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode/funct
// constants, ALU operation codes, datapath mux encodings and the 4-bit
// state encoding used by the main control FSM.
package mips_defs_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State encoding
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_DECODE    = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
    localparam logic [3:0] ST_MEM_READ  = 4'd4;
    localparam logic [3:0] ST_MEM_WB    = 4'd5;
    localparam logic [3:0] ST_MEM_WRITE = 4'd6;
    localparam logic [3:0] ST_EXECUTE   = 4'd7;
    localparam logic [3:0] ST_R_WB      = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_JUMP      = 4'd10;
    localparam logic [3:0] ST_ADDI_EXEC = 4'd11;
    localparam logic [3:0] ST_ADDI_WB   = 4'd12;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_MEM_ADDR  = ST_MEM_ADDR,
        S_MEM_READ  = ST_MEM_READ,
        S_MEM_WB    = ST_MEM_WB,
        S_MEM_WRITE = ST_MEM_WRITE,
        S_EXECUTE   = ST_EXECUTE,
        S_R_WB      = ST_R_WB,
        S_BRANCH    = ST_BRANCH,
        S_JUMP      = ST_JUMP,
        S_ADDI_EXEC = ST_ADDI_EXEC,
        S_ADDI_WB   = ST_ADDI_WB
    } state_e;

endpackage

// File: rtl/alu_funct_decoder.sv
// Combinational R-type funct decoder.
// Ports:
//   funct_i        6  instr[5:0]
//   alu_op_o       4  ALU operation for the funct (ADD when not legal)
//   funct_legal_o  1  funct is one of the supported R-type operations
module alu_funct_decoder
    import mips_defs_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       funct_legal_o
);

    always_comb begin
        alu_op_o      = ALU_ADD;
        funct_legal_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_NOR:  alu_op_o = ALU_NOR;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: funct_legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. One state per cycle;
// outputs are a Moore decode of the state except pc_en (FETCH, BRANCH) and
// illegal_op (DECODE), which also look at inputs.
//
// state      | meaning
// IDLE       | post-reset, outputs quiet, go to FETCH
// FETCH      | read instruction at PC, PC+4; waits on mem_ready
// DECODE     | compute branch target, dispatch on opcode/funct
// MEM_ADDR   | regA + sign-ext imm for lw/sw
// MEM_READ   | data read at ALUOut; waits on mem_ready
// MEM_WB     | write MDR into rt
// MEM_WRITE  | data write at ALUOut; waits on mem_ready
// EXECUTE    | R-type ALU op from funct
// R_WB       | write ALUOut into rd
// BRANCH     | beq compare (SUB), load PC from ALUOut if zero
// JUMP       | load PC with jump target
// ADDI_EXEC  | regA + sign-ext imm
// ADDI_WB    | write ALUOut into rt
//
// Ports:
//   clock_i, reset_n_i           clock, async active-low reset
//   opcode_i, funct_i            instruction fields from the IR
//   zero_i                       ALU zero flag
//   mem_ready_i                  memory completes access this cycle
//   pc_en_o .. alu_operation_o   datapath enables and mux selects
//   illegal_op_o                 unsupported instruction seen in DECODE
//   instr_count_o                instructions fetched since reset (wraps)
module mips_multicycle_ctrl
    import mips_defs_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic [5:0]             opcode_i,
    input  logic [5:0]             funct_i,
    input  logic                   zero_i,
    input  logic                   mem_ready_i,
    output logic                   pc_en_o,
    output logic                   ir_write_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic                   i_or_d_o,
    output logic                   reg_write_o,
    output logic                   reg_dst_o,
    output logic                   mem_to_reg_o,
    output logic                   alu_src_a_o,
    output logic [1:0]             alu_src_b_o,
    output logic [1:0]             pc_source_o,
    output logic [3:0]             alu_operation_o,
    output logic                   illegal_op_o,
    output logic [COUNT_WIDTH-1:0] instr_count_o
);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [3:0]             funct_alu_op;
    logic                   funct_legal;

    alu_funct_decoder u_funct_dec (
        .funct_i      (funct_i),
        .alu_op_o     (funct_alu_op),
        .funct_legal_o(funct_legal)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign instr_count_o = count_q;

    always_comb begin
        state_d         = S_IDLE;
        count_d         = count_q;
        pc_en_o         = 1'b0;
        ir_write_o      = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        i_or_d_o        = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_REGB;
        pc_source_o     = PCSRC_ALU;
        alu_operation_o = ALU_AND;
        illegal_op_o    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_read_o      = 1'b1;
                alu_src_b_o     = SRCB_FOUR;
                alu_operation_o = ALU_ADD;
                pc_source_o     = PCSRC_ALU;
                if (mem_ready_i) begin
                    pc_en_o    = 1'b1;
                    ir_write_o = 1'b1;
                    count_d    = count_q + COUNT_WIDTH'(1);
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_DECODE: begin
                alu_src_b_o     = SRCB_IMM_SH2;
                alu_operation_o = ALU_ADD;
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_RTYPE: begin
                        if (funct_legal) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_op_o = 1'b1;
                            state_d      = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op_o = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = SRCB_IMM;
                alu_operation_o = ALU_ADD;
                state_d         = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end

            S_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                state_d    = mem_ready_i ? S_MEM_WB : S_MEM_READ;
            end

            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                state_d     = mem_ready_i ? S_FETCH : S_MEM_WRITE;
            end

            S_EXECUTE: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = SRCB_REGB;
                alu_operation_o = funct_alu_op;
                state_d         = S_R_WB;
            end

            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                state_d     = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = SRCB_REGB;
                alu_operation_o = ALU_SUB;
                pc_source_o     = PCSRC_ALUOUT;
                pc_en_o         = zero_i;
                state_d         = S_FETCH;
            end

            S_JUMP: begin
                pc_source_o = PCSRC_JUMP;
                pc_en_o     = 1'b1;
                state_d     = S_FETCH;
            end

            S_ADDI_EXEC: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = SRCB_IMM;
                alu_operation_o = ALU_ADD;
                state_d         = S_ADDI_WB;
            end

            S_ADDI_WB: begin
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
            end

            // Unused encodings fall back to IDLE.
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a per-cycle vector table plus a
// hand-written reset-abort sequence. A second instance with a 2-bit counter
// tracks the low bits of the main count to exercise wrap-around.
module tb_mips_multicycle_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_operation;
    logic [31:0] instr_count;

    logic       pc_en2, ir_write2, mem_read2, mem_write2, i_or_d2, reg_write2;
    logic       reg_dst2, mem_to_reg2, alu_src_a2, illegal_op2;
    logic [1:0] alu_src_b2, pc_source2;
    logic [3:0] alu_operation2;
    logic [1:0] instr_count2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mips_multicycle_ctrl #(.COUNT_WIDTH(32)) dut (
        .clock_i(clock), .reset_n_i(reset_n), .opcode_i(opcode), .funct_i(funct),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en), .ir_write_o(ir_write), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .i_or_d_o(i_or_d), .reg_write_o(reg_write),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .pc_source_o(pc_source),
        .alu_operation_o(alu_operation), .illegal_op_o(illegal_op),
        .instr_count_o(instr_count)
    );

    mips_multicycle_ctrl #(.COUNT_WIDTH(2)) dut_w (
        .clock_i(clock), .reset_n_i(reset_n), .opcode_i(opcode), .funct_i(funct),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en2), .ir_write_o(ir_write2), .mem_read_o(mem_read2),
        .mem_write_o(mem_write2), .i_or_d_o(i_or_d2), .reg_write_o(reg_write2),
        .reg_dst_o(reg_dst2), .mem_to_reg_o(mem_to_reg2), .alu_src_a_o(alu_src_a2),
        .alu_src_b_o(alu_src_b2), .pc_source_o(pc_source2),
        .alu_operation_o(alu_operation2), .illegal_op_o(illegal_op2),
        .instr_count_o(instr_count2)
    );

    // {pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[3:0], illegal}
    logic [17:0] ctrl;
    assign ctrl = {pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_operation, illegal_op};

    localparam logic [17:0] E_ZERO    = 18'b0_0_0_0_0_0_0_0_0_00_00_0000_0;
    localparam logic [17:0] E_FGO     = 18'b1_1_1_0_0_0_0_0_0_01_00_0010_0;
    localparam logic [17:0] E_FWAIT   = 18'b0_0_1_0_0_0_0_0_0_01_00_0010_0;
    localparam logic [17:0] E_DEC     = 18'b0_0_0_0_0_0_0_0_0_11_00_0010_0;
    localparam logic [17:0] E_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_11_00_0010_1;
    localparam logic [17:0] E_MADDR   = 18'b0_0_0_0_0_0_0_0_1_10_00_0010_0;
    localparam logic [17:0] E_MRD     = 18'b0_0_1_0_1_0_0_0_0_00_00_0000_0;
    localparam logic [17:0] E_MWB     = 18'b0_0_0_0_0_1_0_1_0_00_00_0000_0;
    localparam logic [17:0] E_MWR     = 18'b0_0_0_1_1_0_0_0_0_00_00_0000_0;
    localparam logic [17:0] E_EX_SUB  = 18'b0_0_0_0_0_0_0_0_1_00_00_0110_0;
    localparam logic [17:0] E_EX_SLT  = 18'b0_0_0_0_0_0_0_0_1_00_00_0111_0;
    localparam logic [17:0] E_EX_AND  = 18'b0_0_0_0_0_0_0_0_1_00_00_0000_0;
    localparam logic [17:0] E_EX_NOR  = 18'b0_0_0_0_0_0_0_0_1_00_00_1100_0;
    localparam logic [17:0] E_RWB     = 18'b0_0_0_0_0_1_1_0_0_00_00_0000_0;
    localparam logic [17:0] E_BR_T    = 18'b1_0_0_0_0_0_0_0_1_00_01_0110_0;
    localparam logic [17:0] E_BR_N    = 18'b0_0_0_0_0_0_0_0_1_00_01_0110_0;
    localparam logic [17:0] E_JMP     = 18'b1_0_0_0_0_0_0_0_0_00_10_0000_0;
    localparam logic [17:0] E_AWB     = 18'b0_0_0_0_0_1_0_0_0_00_00_0000_0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [17:0] exp;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input logic [17:0] exp, input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.exp = exp; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        // lw with one MEM_READ wait cycle
        add(6'h23, 6'h00, 1'b0, 1'b1, E_ZERO,   0);
        add(6'h23, 6'h00, 1'b0, 1'b1, E_FGO,    0);
        add(6'h23, 6'h00, 1'b0, 1'b1, E_DEC,    1);
        add(6'h23, 6'h00, 1'b0, 1'b1, E_MADDR,  1);
        add(6'h23, 6'h00, 1'b0, 1'b0, E_MRD,    1);
        add(6'h23, 6'h00, 1'b0, 1'b1, E_MRD,    1);
        add(6'h23, 6'h00, 1'b0, 1'b1, E_MWB,    1);
        // R-type sub, slt, and, nor
        add(6'h00, 6'h22, 1'b0, 1'b1, E_FGO,    1);
        add(6'h00, 6'h22, 1'b0, 1'b1, E_DEC,    2);
        add(6'h00, 6'h22, 1'b0, 1'b1, E_EX_SUB, 2);
        add(6'h00, 6'h22, 1'b0, 1'b1, E_RWB,    2);
        add(6'h00, 6'h2A, 1'b0, 1'b1, E_FGO,    2);
        add(6'h00, 6'h2A, 1'b0, 1'b1, E_DEC,    3);
        add(6'h00, 6'h2A, 1'b0, 1'b1, E_EX_SLT, 3);
        add(6'h00, 6'h2A, 1'b0, 1'b1, E_RWB,    3);
        add(6'h00, 6'h24, 1'b0, 1'b1, E_FGO,    3);
        add(6'h00, 6'h24, 1'b0, 1'b1, E_DEC,    4);
        add(6'h00, 6'h24, 1'b0, 1'b1, E_EX_AND, 4);
        add(6'h00, 6'h24, 1'b0, 1'b1, E_RWB,    4);
        add(6'h00, 6'h27, 1'b0, 1'b1, E_FGO,    4);
        add(6'h00, 6'h27, 1'b0, 1'b1, E_DEC,    5);
        add(6'h00, 6'h27, 1'b0, 1'b1, E_EX_NOR, 5);
        add(6'h00, 6'h27, 1'b0, 1'b1, E_RWB,    5);
        // addi
        add(6'h08, 6'h00, 1'b0, 1'b1, E_FGO,    5);
        add(6'h08, 6'h00, 1'b0, 1'b1, E_DEC,    6);
        add(6'h08, 6'h00, 1'b0, 1'b1, E_MADDR,  6);
        add(6'h08, 6'h00, 1'b0, 1'b1, E_AWB,    6);
        // beq taken, then not taken
        add(6'h04, 6'h00, 1'b0, 1'b1, E_FGO,    6);
        add(6'h04, 6'h00, 1'b0, 1'b1, E_DEC,    7);
        add(6'h04, 6'h00, 1'b1, 1'b1, E_BR_T,   7);
        add(6'h04, 6'h00, 1'b1, 1'b1, E_FGO,    7);
        add(6'h04, 6'h00, 1'b1, 1'b1, E_DEC,    8);
        add(6'h04, 6'h00, 1'b0, 1'b1, E_BR_N,   8);
        // j with zero high (must not matter)
        add(6'h02, 6'h00, 1'b1, 1'b1, E_FGO,    8);
        add(6'h02, 6'h00, 1'b1, 1'b1, E_DEC,    9);
        add(6'h02, 6'h00, 1'b0, 1'b1, E_JMP,    9);
        // FETCH stalled 3 cycles, then sw
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_FWAIT,  9);
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_FWAIT,  9);
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_FWAIT,  9);
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_FGO,    9);
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_DEC,    10);
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_MADDR,  10);
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_MWR,    10);
        // illegal opcode, then illegal R-type funct
        add(6'h3F, 6'h00, 1'b0, 1'b1, E_FGO,    10);
        add(6'h3F, 6'h00, 1'b0, 1'b1, E_DEC_ILL, 11);
        add(6'h00, 6'h00, 1'b0, 1'b1, E_FGO,    11);
        add(6'h00, 6'h00, 1'b0, 1'b1, E_DEC_ILL, 12);
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_FGO,    12);

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("reset_ctrl", -1, 32'(ctrl), 32'(E_ZERO));
        chk("reset_count", -1, instr_count, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            opcode    = tbl[i].op;
            funct     = tbl[i].fn;
            zero      = tbl[i].z;
            mem_ready = tbl[i].mr;
            #1;
            chk("ctrl", i, 32'(ctrl), 32'(tbl[i].exp));
            chk("count", i, instr_count, tbl[i].cnt);
            chk("count_wrap", i, 32'(instr_count2), 32'(tbl[i].cnt[1:0]));
            if (mem_write && reg_write) chk("wr_excl", i, 32'(1), 32'(0));
            @(negedge clock);
        end

        // Reset abort in the middle of a stalled MEM_WRITE (sw, count 13)
        opcode = 6'h2B; mem_ready = 1'b0;
        #1 chk("abort_dec", 0, 32'(ctrl), 32'(E_DEC));
        @(negedge clock);
        #1 chk("abort_maddr", 1, 32'(ctrl), 32'(E_MADDR));
        @(negedge clock);
        #1 chk("abort_mwr", 2, 32'(ctrl), 32'(E_MWR));
        @(negedge clock);
        #1 chk("abort_mwr_hold", 3, 32'(ctrl), 32'(E_MWR));
        chk("abort_count_pre", 3, instr_count, 32'd13);
        #1 reset_n = 1'b0;
        #1 chk("abort_ctrl", 4, 32'(ctrl), 32'(E_ZERO));
        chk("abort_count", 4, instr_count, 32'd0);
        @(negedge clock);
        reset_n = 1'b1; mem_ready = 1'b1;
        #1 chk("restart_idle", 5, 32'(ctrl), 32'(E_ZERO));
        @(negedge clock);
        #1 chk("restart_fetch", 6, 32'(ctrl), 32'(E_FGO));
        chk("restart_count0", 6, instr_count, 32'd0);
        @(negedge clock);
        #1 chk("restart_dec", 7, 32'(ctrl), 32'(E_DEC));
        chk("restart_count1", 7, instr_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
